// File: rtl/paraserial_sched_if.sv
// Byte-requester and serial-link signal bundle for paraserial_sched.
// The master drives the four lane requests and sync_req; the scheduler drives the serial side.
interface paraserial_sched_if;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic       valid_in0;
  logic       valid_in1;
  logic       valid_in2;
  logic       valid_in3;
  logic       sync_req;
  logic       data_out;
  logic       byte_start;
  logic [1:0] lane_sel;
  logic       lane_valid;
  logic [3:0] ack;

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3, sync_req,
    input  data_out, byte_start, lane_sel, lane_valid, ack
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3, sync_req,
    output data_out, byte_start, lane_sel, lane_valid, ack
  );
endinterface

// File: rtl/paraserial_sched.sv
// Round-robin scheduler sharing one MSB-first serial lane between four byte requesters.
// Runs on the 8x bit clock: every eighth edge loads a COM, IDL or granted requester byte.
//
// state  | meaning
// S_SYNC   | sending SYNC_BYTES COM symbols; requests and sync_req ignored
// S_ACTIVE | each byte slot goes to the next valid lane round-robin, else IDL
module paraserial_sched #(
  parameter int         SYNC_BYTES = 4,
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDL_SYM    = 8'h7C
) (
  input logic              clk_8f,
  input logic              reset,
  paraserial_sched_if.slave bus
);
  localparam int CNT_W = $clog2(SYNC_BYTES + 1);

  typedef enum logic {S_SYNC, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             byte_start_q, byte_start_d;
  logic [3:0]       ack_q, ack_d;
  logic [1:0]       lane_sel_q, lane_sel_d;
  logic             lane_valid_q, lane_valid_d;

  logic       load;
  logic [3:0] lane_req;
  logic [7:0] lane_data [4];
  logic       found;
  logic [1:0] gnt_idx;
  logic [1:0] probe;

  assign load         = (bit_cnt_q == 3'd7);
  assign lane_req     = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign lane_data[0] = bus.data_in0;
  assign lane_data[1] = bus.data_in1;
  assign lane_data[2] = bus.data_in2;
  assign lane_data[3] = bus.data_in3;

  // Search starts one past the last winner; offset 4 wraps back onto rr_ptr itself.
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_ptr_q;
    probe   = '0;
    for (int i = 1; i <= 4; i++) begin
      probe = rr_ptr_q + 2'(i);
      if (!found && lane_req[probe]) begin
        found   = 1'b1;
        gnt_idx = probe;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    shreg_d      = {shreg_q[6:0], 1'b0};
    byte_start_d = 1'b0;
    ack_d        = 4'b0000;
    lane_sel_d   = lane_sel_q;
    lane_valid_d = lane_valid_q;
    if (load) begin
      byte_start_d = 1'b1;
      lane_valid_d = 1'b0;
      shreg_d      = IDL_SYM;
      case (state_q)
        S_SYNC: begin
          shreg_d = COM_SYM;
          if (sync_cnt_q == CNT_W'(SYNC_BYTES - 1)) begin
            state_d    = S_ACTIVE;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (bus.sync_req) begin
            state_d    = S_SYNC;
            sync_cnt_d = CNT_W'(1);
            shreg_d    = COM_SYM;
          end else if (found) begin
            shreg_d      = lane_data[gnt_idx];
            ack_d        = 4'b0001 << gnt_idx;
            lane_sel_d   = gnt_idx;
            lane_valid_d = 1'b1;
            rr_ptr_d     = gnt_idx;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q      <= S_SYNC;
      bit_cnt_q    <= 3'd7;
      shreg_q      <= '0;
      sync_cnt_q   <= '0;
      rr_ptr_q     <= 2'd3;
      byte_start_q <= 1'b0;
      ack_q        <= 4'b0000;
      lane_sel_q   <= 2'd0;
      lane_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_q + 3'd1;
      shreg_q      <= shreg_d;
      sync_cnt_q   <= sync_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_start_q <= byte_start_d;
      ack_q        <= ack_d;
      lane_sel_q   <= lane_sel_d;
      lane_valid_q <= lane_valid_d;
    end
  end

  assign bus.data_out   = shreg_q[7];
  assign bus.byte_start = byte_start_q;
  assign bus.ack        = ack_q;
  assign bus.lane_sel   = lane_sel_q;
  assign bus.lane_valid = lane_valid_q;
endmodule

// File: doc/paraserial_sched.md
Name: paraserial_sched

Overview:
- Round-robin scheduler sharing one 8-bit parallel-to-serial lane between four byte requesters; runs on the 8x bit clock.
- After reset, sends a COM sync burst; then each byte slot goes to the next valid requester, or to an idle symbol when none is valid.
- Acknowledges the granted requester and shifts the byte out MSB first.
- Sits between per-lane byte sources (clk_f domain, phase-aligned) and the serial link.

Parameters:
- SYNC_BYTES, 4, number of COM bytes sent after reset or after a sync_req
- COM_SYM, 8'hBC, sync symbol
- IDL_SYM, 8'h7C, idle symbol sent when no lane is valid in ACTIVE

Ports:
- clk_8f  in  1  bit clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in0..data_in3  in  8 each  byte offered by lane i
- valid_in0..valid_in3  in  1 each  lane i requests a slot; data and valid held until ack
- sync_req  in  1  request a COM resync at the next byte boundary (level, sampled at boundary)
- data_out  out  1  serial bit = bit 7 of shift register
- byte_start  out  1  high while data_out carries bit 7 of a byte
- lane_sel  out  2  source lane of byte currently shifting (valid only when lane_valid=1)
- lane_valid  out  1  current byte is requester data, not COM/IDL
- ack  out  4  one-hot; lane i's byte was loaded; high exactly one clk_8f cycle

Behaviour:
- Reset values:
  - shreg=0, data_out=0, bit_cnt=7, state=SYNC, sync_cnt=0, rr_ptr=3 (so lane 0 wins first)
  - ack=0, byte_start=0, lane_sel=0, lane_valid=0
- Bit counter:
  - 3 bits, increments every edge, wraps 7->0.
  - The edge where bit_cnt goes 7->0 is the load edge. On every other edge shreg shifts left, filling with 0.
- Load-edge actions, all registered:
  - load shreg
  - set byte_start=1 (cleared on the following edge)
  - set ack / lane_sel / lane_valid
- Latency: a byte granted on load edge N appears MSB on data_out in the cycle after edge N; its LSB appears 7 cycles later. Each byte occupies 8 cycles.
- State SYNC:
  - Load COM_SYM; no ack; lane_valid=0; sync_cnt++.
  - When sync_cnt reaches SYNC_BYTES on a load edge (i.e. after the SYNC_BYTES-th COM), go to ACTIVE and clear sync_cnt.
  - sync_req is ignored in SYNC.
- State ACTIVE, evaluated at each load edge:
  - If sync_req=1: go to SYNC and load COM (counts as first sync byte, sync_cnt=1). No grant that slot.
  - Else if any valid_in:
    - Search lanes starting at rr_ptr+1 mod 4; the first valid lane g wins.
    - Load data_in_g; ack[g]=1; lane_sel=g; lane_valid=1; rr_ptr=g.
  - Else: load IDL_SYM, lane_valid=0, rr_ptr unchanged.
- Inputs are sampled only at the load edge; valid changes mid-byte have no effect.
- Requester contract: after seeing ack, advance data or drop valid before the next load edge, 8 cycles later.
- A lane holding valid continuously gets at most one slot per 4 if all lanes are valid; alone, it gets every slot.
- Reset asserted mid-byte: outputs clear immediately, the partial byte is lost, and the next sequence restarts with SYNC_BYTES COMs. The first load edge is the first rising edge after reset deasserts.
- Simultaneous sync_req and valid: sync wins; the requester keeps valid and is served after resync with rr_ptr unchanged.

Test Plan:
- Reset then release, all valid_in=0 -> 4 bytes of 0xBC (bits 1,0,1,1,1,1,0,0), then 0x7C repeating; ack never asserted; byte_start every 8th cycle.
- After sync, valid_in0=1 with data_in0 incrementing 0x01.. on each ack -> serial bytes 0x01,0x02,0x03 back-to-back, lane_sel=0, lane_valid=1, ack[0] pulses every 8 cycles.
- All four lanes valid with data 0xA0,0xB1,0xC2,0xD3 -> order lanes 0,1,2,3,0; ack one-hot 0001,0010,0100,1000,0001 at 8-cycle spacing.
- Lanes 1 and 3 valid, rr_ptr=1 -> lane 3 served, then lane 1; lane 1 dropping valid mid-byte still gets no slot until it reasserts at a load edge.
- sync_req pulsed high across a load edge while lane 2 valid -> 4 COM bytes, no ack, then lane 2 granted on the next slot.
- reset asserted at bit_cnt=3 of a data byte -> data_out=0 and ack=0 immediately; after release, 4×0xBC before any grant.
